// File: rtl/bn_relu_pool.sv
// ReLU followed by non-overlapping 1-D max-pooling over POOL accepted samples.
// One output register with valid/ready; the input is held off only when a
// window would close while that register still holds an unconsumed result.
module bn_relu_pool #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 8,
   parameter int POOL  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [WIDTH-1:0]               x_in,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           flush,
   output logic [WIDTH-1:0]               y_out,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(POOL+1)-1:0]      win_cnt
);

   localparam int CW = $clog2(POOL + 1);

   if (POOL < 2 || POOL > 16 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_params
      $error("bn_relu_pool: illegal parameter set");
   end

   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] max_q, max_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             vld_q, vld_d;

   logic [WIDTH-1:0] relu_x;
   logic [WIDTH-1:0] acc_max;
   logic [WIDTH-1:0] new_max;
   logic [CW-1:0]    new_cnt;
   logic             out_busy;
   logic             accept;
   logic             close;

   assign out_busy = vld_q && !out_ready;
   assign in_ready = !((cnt_q == CW'(POOL - 1)) && out_busy);
   assign accept   = in_valid && in_ready;
   assign relu_x   = x_in[WIDTH-1] ? '0 : x_in;

   // A fresh window starts from the sample itself, never from the stale max.
   assign acc_max  = ((cnt_q == '0) || (relu_x > max_q)) ? relu_x : max_q;

   always_comb begin
      new_max = max_q;
      new_cnt = cnt_q;
      if (accept) begin
         new_max = acc_max;
         new_cnt = cnt_q + CW'(1);
      end

      // A flush only counts if the window is non-empty once this cycle's
      // sample is included, and it waits for the output register to drain.
      close = (accept && (new_cnt == CW'(POOL)))
           || (flush && (new_cnt != '0) && !out_busy);

      y_d   = y_q;
      vld_d = vld_q && !out_ready;
      cnt_d = new_cnt;
      max_d = new_max;
      if (close) begin
         y_d   = new_max;
         vld_d = 1'b1;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y_q   <= '0;
         max_q <= '0;
         cnt_q <= '0;
         vld_q <= 1'b0;
      end else begin
         y_q   <= y_d;
         max_q <= max_d;
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   assign y_out     = y_q;
   assign out_valid = vld_q;
   assign win_cnt   = cnt_q;

endmodule
